// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared types and constants for the FPU result logger.
//   state_t         : logger FSM states (CLEAR sweep, LOG accepting, FULL stopped)
//   WORD_WIDTH32    : width of one FPU operand/result word
//   LOG_ADDR_WIDTH  : default log2 of the log depth
//   ENTRY_WIDTH     : width of one stored {A,B,C} entry
// -----------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOG   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int WORD_WIDTH32   = 32;
    localparam int LOG_ADDR_WIDTH = 5;
    localparam int ENTRY_WIDTH    = 3 * WORD_WIDTH32;

endpackage : fpu_pkg

// File: rtl/log_ram.sv
// -----------------------------------------------------------------------------
// log_ram
// Simple dual-port RAM: one write port, one synchronous read port, both on
// posedge clk. A read and a write to the same address on the same edge return
// the old contents (read-before-write). No initial contents and no reset.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_q loads mem[rd_addr] on the edge
//   rd_addr  : read address
//   rd_q     : registered read data (holds when rd_en is low)
// -----------------------------------------------------------------------------
module log_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 96
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    (* ramstyle = "M9K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; the
    // owner zeroes it with a write sweep instead.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make the read sample mem before the
        // write on the same edge lands, which is what gives read-before-write.
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule : log_ram

// File: rtl/fpu_result_logger.sv
// -----------------------------------------------------------------------------
// fpu_result_logger
// Captures FPU test results {A,B,C} into an on-chip log RAM, one entry per
// accepted result, and reads entries back by index. After reset the RAM is
// swept to zero (CLEAR), then results are logged (LOG). With WRAP=0 the block
// stops in FULL once every entry is used; with WRAP=1 it overwrites the oldest.
//
// Optional feature (compile-time macro FPU_LOG_CHECKSUM_EN):
//   adds output chk, the running XOR of in_a^in_b^in_c over every accepted
//   entry (overwrites included, nothing is ever subtracted).
//
// Ports:
//   clk        : clock, all logic on posedge
//   reset      : synchronous, active-high; restarts the clear sweep
//   in_valid   : result present
//   in_a/b/c   : operand A, operand B, result C
//   in_ready   : block can accept an entry (registered)
//   rd_en      : readback request, ignored during CLEAR
//   rd_addr    : entry index to read
//   rd_valid   : rd_data valid this cycle (one-cycle pulse per rd_en)
//   rd_data    : {A,B,C}, A in the MSBs; zero when rd_valid is low
//   count      : number of valid entries, saturating at the depth
//   full       : count equals the depth
//   chk        : running checksum (only with FPU_LOG_CHECKSUM_EN)
//   busy       : clear sweep in progress
// -----------------------------------------------------------------------------
module fpu_result_logger
    import fpu_pkg::*;
#(
    parameter int ADDR_WIDTH = LOG_ADDR_WIDTH,
    parameter int WORD_WIDTH = WORD_WIDTH32,
    parameter int WRAP       = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [WORD_WIDTH-1:0]   in_a,
    input  logic [WORD_WIDTH-1:0]   in_b,
    input  logic [WORD_WIDTH-1:0]   in_c,
    output logic                    in_ready,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_valid,
    output logic [3*WORD_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    full,
`ifdef FPU_LOG_CHECKSUM_EN
    output logic [WORD_WIDTH-1:0]   chk,
`endif
    output logic                    busy
);

    localparam int                  EW        = 3 * WORD_WIDTH;
    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic                    handshake;

    logic                    ram_wr_en;
    logic [ADDR_WIDTH-1:0]   ram_wr_addr;
    logic [EW-1:0]           ram_wr_data;
    logic                    ram_rd_en;
    logic [EW-1:0]           ram_q;

    // in_ready is high only in LOG, so this is also the LOG-state write strobe.
    assign handshake = in_valid && in_ready;

    // Write port is shared between the clear sweep and logging. Nothing is
    // written in a reset cycle, so a stray handshake cannot slip in there.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and no latch is inferred.
        ram_wr_en   = 1'b0;
        ram_wr_addr = wr_ptr;
        ram_wr_data = '0;
        if (!reset) begin
            if (state == CLEAR) begin
                ram_wr_en   = 1'b1;
                ram_wr_addr = clr_ptr;
            end else if (handshake) begin
                ram_wr_en   = 1'b1;
                ram_wr_data = {in_a, in_b, in_c};
            end
        end
    end

    assign ram_rd_en = rd_en && (state != CLEAR) && !reset;

    log_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (EW)
    ) u_log_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_addr),
        .rd_q    (ram_q)
    );

    // The RAM output register carries no reset, so the visible data is gated
    // by rd_valid; this also gives rd_data=0 straight out of reset.
    assign rd_data = rd_valid ? ram_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            rd_valid <= 1'b0;
`ifdef FPU_LOG_CHECKSUM_EN
            chk      <= '0;
`endif
        end else begin
            rd_valid <= rd_en && (state != CLEAR);

            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == '1) begin
                        state    <= LOG;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                LOG: begin
                    if (handshake) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        // Once saturated (WRAP=1 only) the write replaces the
                        // oldest entry and count/full stay where they are.
                        if (count != DEPTH_CNT) begin
                            count <= count + 1'b1;
                            if (count == DEPTH_CNT - 1'b1) begin
                                full <= 1'b1;
                                if (WRAP == 0) begin
                                    state    <= FULL;
                                    in_ready <= 1'b0;
                                end
                            end
                        end
                    end
                end

                FULL: begin
                    // Terminal until reset; readback is still served.
                end

                default: begin
                    state    <= CLEAR;
                    clr_ptr  <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
            endcase

`ifdef FPU_LOG_CHECKSUM_EN
            if (handshake) begin
                chk <= chk ^ in_a ^ in_b ^ in_c;
            end
`endif
        end
    end

endmodule : fpu_result_logger
